// File: rtl/btn_debounce.sv
// Push-button conditioner: polarity normalisation, two-flop synchroniser and a
// stability-counter debounce FSM producing a clean level plus press/release pulses.
module btn_debounce #(
    parameter int STABLE_CYCLES = 1000000,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int CNT_WIDTH     = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk_50MHZ,
    input  logic rstn_i,
    input  logic btn_i,
    output logic btn_state_o,
    output logic press_o,
    output logic release_o
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    logic                 pressed_raw;
    logic                 sync_q1;
    logic                 sync_q2;
    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 btn_state_q;
    logic                 press_q;
    logic                 release_q;

    // Polarity is fixed before the synchroniser so both flops idle at "not pressed".
    assign pressed_raw = btn_i ^ ACTIVE_LOW;

    always_ff @(posedge clk_50MHZ or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= pressed_raw;
            sync_q2 <= sync_q1;
        end
    end

    always_ff @(posedge clk_50MHZ or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            btn_state_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sync_q2) begin
                        state_q <= PRESS_WAIT;
                        cnt_q   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sync_q2) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= PRESSED;
                        cnt_q       <= '0;
                        btn_state_q <= 1'b1;
                        press_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!sync_q2) begin
                        state_q <= RELEASE_WAIT;
                        cnt_q   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back high returns to PRESSED silently; the level never dropped.
                    if (sync_q2) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q     <= IDLE;
                        cnt_q       <= '0;
                        btn_state_q <= 1'b0;
                        release_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cnt_q       <= '0;
                    btn_state_q <= 1'b0;
                end
            endcase
        end
    end

    assign btn_state_o = btn_state_q;
    assign press_o     = press_q;
    assign release_o   = release_q;

    a_pulses_exclusive: assert property (@(posedge clk_50MHZ) disable iff (!rstn_i)
        !(press_q && release_q));
    a_press_single: assert property (@(posedge clk_50MHZ) disable iff (!rstn_i)
        press_q |=> !press_q);
    a_release_single: assert property (@(posedge clk_50MHZ) disable iff (!rstn_i)
        release_q |=> !release_q);

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Conditions one raw push-button input before it reaches the top-level control logic (enable/reset) of the board device.
- Synchronises the asynchronous button into the 50 MHz domain and normalises its polarity.
- Filters contact bounce with a stability counter.
- Produces a clean debounced level, a one-cycle press pulse and a one-cycle release pulse; one instance per button.

Parameters:
- STABLE_CYCLES, 1000000, consecutive synchronised samples at the new level required to accept a change (20 ms at 50 MHz); legal range >= 1.
- ACTIVE_LOW, 1, 1: raw pin reads 0 when pressed (board keys); 0: raw pin reads 1 when pressed.
- CNT_WIDTH, $clog2(STABLE_CYCLES+1), stability counter width.

Ports:
- clk_50MHZ  input  1  system clock, 50 MHz.
- rstn_i  input  1  reset, asynchronous, active-low; one clock, asynchronous active-low reset.
- btn_i  input  1  raw button pin, asynchronous to clk_50MHZ.
- btn_state_o  output  1  debounced level, 1 = pressed.
- press_o  output  1  single-cycle pulse on an accepted press.
- release_o  output  1  single-cycle pulse on an accepted release.

Behaviour:
- Polarity: pressed_raw = btn_i XOR ACTIVE_LOW, applied before synchronisation.
- Synchroniser: 2-flop chain sync_q1 -> sync_q2; both reset to 0 (not pressed). The FSM uses only sync_q2.
- Reset (rstn_i low, asynchronous): FSM = IDLE, counter = 0, sync flops = 0, btn_state_o = 0, press_o = 0, release_o = 0. Holds while rstn_i is low. Deassertion is the only synchronous-release requirement; the first active edge after release behaves as IDLE.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- IDLE: sync_q2 = 1 -> PRESS_WAIT, cnt = 0; else stay.
- PRESS_WAIT:
  - sync_q2 = 0 -> IDLE, cnt = 0 (bounce rejected, no pulse).
  - sync_q2 = 1 and cnt = STABLE_CYCLES-1 -> PRESSED; btn_state_o <= 1; press_o <= 1 for exactly one cycle.
  - otherwise cnt <= cnt+1.
- PRESSED: sync_q2 = 0 -> RELEASE_WAIT, cnt = 0; else stay.
- RELEASE_WAIT:
  - sync_q2 = 1 -> PRESSED, cnt = 0 (no pulse, btn_state_o stays 1).
  - sync_q2 = 0 and cnt = STABLE_CYCLES-1 -> IDLE; btn_state_o <= 0; release_o <= 1 for one cycle.
  - otherwise cnt <= cnt+1.
- All outputs are registered. press_o and release_o are never high together and never high for two consecutive cycles.
- Latency: pressed_raw first sampled high at edge 0 and held. btn_state_o and press_o go high after edge STABLE_CYCLES+2; press_o falls after edge STABLE_CYCLES+3. Release is symmetric.
- The counter never exceeds STABLE_CYCLES-1 and does not wrap. Any level change during a WAIT state restarts filtering from the opposite stable state.
- STABLE_CYCLES = 1: a single stable sample after the synchroniser is accepted (latency 3 edges).
- Unknown/illegal state encoding -> IDLE with outputs 0.
- Reset asserted mid-WAIT or in PRESSED: outputs drop to 0 immediately; no release_o pulse is generated.

Test Plan:
- All scenarios use STABLE_CYCLES=4, ACTIVE_LOW=0, 20 ns clock.
- Clean press: btn_i 0->1 sampled at edge 0, held 30 cycles -> btn_state_o=1 and press_o=1 after edge 6; press_o=0 after edge 7; release_o stays 0.
- Bounce: btn_i toggles every 2 cycles for 12 cycles, then holds 1 for 20 cycles -> exactly one press_o pulse, 6 edges after the final rising sample; btn_state_o never pulses.
- Glitch rejection: btn_i high for 3 cycles, otherwise 0 -> press_o, release_o, btn_state_o remain 0 throughout.
- Release: from PRESSED, btn_i 1->0 held 20 cycles -> release_o one cycle and btn_state_o=0 after edge 6. A 2-cycle low dip from PRESSED -> no release_o, btn_state_o stays 1.
- Async reset: rstn_i pulled low between edges during PRESS_WAIT (cnt=2) and during PRESSED -> all outputs 0 immediately, no pulses. After release with btn_i held 1 -> a fresh press_o after 6 edges.
- Polarity: ACTIVE_LOW=1, btn_i idle at 1 after reset for 20 cycles -> no press_o. btn_i driven 0 and held -> press_o after edge 6.
